// File: rtl/compress_pack_if.sv
// ---------------------------------------------------------------------------
// compress_pack_if
//   Bundles the control handshake and both RAM ports of compress_pack.
//   master : the compressor side (drives busy/done/err, the RAM addresses,
//            and the byte write data/enable)
//   slave  : the environment side (drives start and the poly RAM read data)
//
//   start       start request, sampled only while the compressor is idle
//   busy        high from start acceptance until done
//   done        one-cycle pulse after the last byte write
//   err         sticky flag: a coefficient >= Q was seen during this run
//   poly_addra  poly RAM read address (PA_W bits)
//   poly_doa    poly RAM read data, valid one cycle after poly_addra
//   byte_addr   byte RAM write address (BA_W bits)
//   byte_di     byte RAM write data
//   byte_we     byte RAM write enable, one cycle per byte
// ---------------------------------------------------------------------------
interface compress_pack_if #(
    parameter int PA_W = 10,
    parameter int BA_W = 9
);
    logic            start;
    logic            busy;
    logic            done;
    logic            err;
    logic [PA_W-1:0] poly_addra;
    logic [15:0]     poly_doa;
    logic [BA_W-1:0] byte_addr;
    logic [7:0]      byte_di;
    logic            byte_we;

    modport master (
        input  start, poly_doa,
        output busy, done, err, poly_addra, byte_addr, byte_di, byte_we
    );

    modport slave (
        output start, poly_doa,
        input  busy, done, err, poly_addra, byte_addr, byte_di, byte_we
    );
endinterface

// File: rtl/compress_pack.sv
// ---------------------------------------------------------------------------
// compress_pack
//   Reads N coefficients from poly RAM (one per cycle), compresses each to
//   c = (((x << D) + Q/2) / Q) mod 2^D, and packs the D-bit results
//   LSB-first into bytes written to byte RAM. Fully pipelined, no stalls.
//   Coefficients >= Q compress to 0 and raise a sticky err flag that is
//   cleared by the next accepted start.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a run immediately
//   bus    compress_pack_if.master: start/busy/done/err, poly RAM read port
//          (poly_addra/poly_doa) and byte RAM write port
//          (byte_addr/byte_di/byte_we)
// ---------------------------------------------------------------------------
module compress_pack #(
    parameter int          N    = 1024,
    parameter int unsigned Q    = 12289,
    parameter int          D    = 3,
    parameter int          PA_W = 10,
    parameter int          BA_W = 9
) (
    input logic             clk,
    input logic             rst_n,
    compress_pack_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam int unsigned     HALF_Q    = Q >> 1;
    localparam int unsigned     NC        = 1 << D;
    localparam logic [PA_W-1:0] LAST_ADDR = PA_W'(N - 1);

    state_t          state;
    logic            rd_v;
    logic            c_v;
    logic [D-1:0]    c_reg;
    logic [6:0]      acc;
    logic [2:0]      acc_cnt;

    logic            in_range;
    logic [D-1:0]    c_cnt;
    logic [D-1:0]    c_next;
    logic [D+6:0]    merged;
    logic [3:0]      merged_cnt;

    // Smallest x for which ((x << D) + Q/2) >= j*Q, i.e. the input at which
    // the rounded quotient reaches j.
    function automatic int unsigned threshold(input int unsigned j);
        return (j * Q - HALF_Q + NC - 1) >> D;
    endfunction

    // Counting the thresholds that x reaches gives the exact rounded quotient.
    // The D-bit counter wraps at 2^D, which is exactly the required mod 2^D.
    always_comb begin
        in_range = 32'(bus.poly_doa) < Q;
        c_cnt    = '0;
        for (int unsigned j = 1; j <= NC; j++) begin
            if (32'(bus.poly_doa) >= threshold(j)) begin
                c_cnt = c_cnt + D'(1);
            end
        end
        c_next = in_range ? c_cnt : '0;
    end

    // The accumulator only ever holds fewer than 8 bits between cycles, so
    // appending one D-bit code fits in 7+D bits and yields at most one byte.
    always_comb begin
        merged     = (D+7)'(acc);
        merged_cnt = {1'b0, acc_cnt};
        if (c_v) begin
            merged     = merged | ((D+7)'(c_reg) << acc_cnt);
            merged_cnt = merged_cnt + 4'(D);
        end
    end

    // Control FSM plus the datapath registers. rd_v marks a cycle where
    // poly_doa holds a requested coefficient, c_v marks a registered code.
    // The run ends once neither stage holds data; by then the final merge
    // has already issued its byte write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.poly_addra <= '0;
            bus.byte_addr  <= '0;
            bus.byte_di    <= '0;
            bus.byte_we    <= 1'b0;
            rd_v           <= 1'b0;
            c_v            <= 1'b0;
            c_reg          <= '0;
            acc            <= '0;
            acc_cnt        <= '0;
        end else begin
            bus.done    <= 1'b0;
            bus.byte_we <= 1'b0;
            rd_v        <= (state == FETCH);
            c_v         <= rd_v;
            c_reg       <= c_next;

            if (rd_v && !in_range) begin
                bus.err <= 1'b1;
            end

            if (bus.byte_we) begin
                bus.byte_addr <= bus.byte_addr + BA_W'(1);
            end

            if (merged_cnt >= 4'd8) begin
                bus.byte_we <= 1'b1;
                bus.byte_di <= merged[7:0];
                acc         <= 7'(merged >> 8);
                acc_cnt     <= 3'(merged_cnt - 4'd8);
            end else begin
                acc         <= merged[6:0];
                acc_cnt     <= merged_cnt[2:0];
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= FETCH;
                        bus.busy       <= 1'b1;
                        bus.err        <= 1'b0;
                        bus.poly_addra <= '0;
                        bus.byte_addr  <= '0;
                    end
                end
                FETCH: begin
                    if (bus.poly_addra == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        bus.poly_addra <= bus.poly_addra + PA_W'(1);
                    end
                end
                DRAIN: begin
                    if (!rd_v && !c_v) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compress_pack.sv
// ---------------------------------------------------------------------------
// tb_compress_pack
//   Bench for compress_pack with three instances: the default (N=1024, D=3),
//   a D=8 instance (N=1024) and a D=1 instance (N=8). Each instance has a
//   poly RAM model with one cycle of read latency and a byte RAM capture
//   monitor that also checks sequential addressing and that writes only
//   happen while busy.
// ---------------------------------------------------------------------------
module tb_compress_pack;

    localparam int unsigned Q      = 12289;
    localparam int          N0     = 1024;
    localparam int          NB0    = 384;
    localparam int          N8     = 1024;
    localparam int          N1     = 8;
    localparam int          BUDGET = 1200;
    localparam int          NV     = 14;

    typedef struct {
        logic [15:0] x;
        logic [2:0]  c;
        logic        err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   cyc;

    compress_pack_if #(.PA_W(10), .BA_W(9))  bus0 ();
    compress_pack_if #(.PA_W(10), .BA_W(10)) bus8 ();
    compress_pack_if #(.PA_W(3),  .BA_W(1))  bus1 ();

    compress_pack #(.N(1024), .Q(Q), .D(3), .PA_W(10), .BA_W(9)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master));
    compress_pack #(.N(1024), .Q(Q), .D(8), .PA_W(10), .BA_W(10)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.master));
    compress_pack #(.N(8), .Q(Q), .D(1), .PA_W(3), .BA_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master));

    // poly RAM models
    logic [15:0] mem0 [N0];
    logic [15:0] mem8 [N8];
    logic [15:0] mem1 [N1];

    // byte RAM captures and monitor statistics
    logic [7:0] cap0 [NB0];
    logic [7:0] cap8 [N8];
    logic [7:0] cap1;
    int wr0, done0, bad0, exp_addr0, acc0, lastwe0, donecyc0;
    int wr8, done8, bad8, exp_addr8;
    int wr1, done1, bad1, exp_addr1;
    bit prev_busy0, prev_busy8, prev_busy1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus0.poly_doa <= mem0[bus0.poly_addra];
        bus8.poly_doa <= mem8[bus8.poly_addra];
        bus1.poly_doa <= mem1[bus1.poly_addra];
    end

    always @(negedge clk) begin
        cyc = cyc + 1;

        if (bus0.busy && !prev_busy0) begin
            exp_addr0 = 0;
            acc0      = cyc;
        end
        prev_busy0 = bus0.busy;
        if (bus0.byte_we) begin
            wr0++;
            lastwe0 = cyc;
            if (!bus0.busy || int'(bus0.byte_addr) != exp_addr0 || exp_addr0 >= NB0) bad0++;
            else cap0[bus0.byte_addr] = bus0.byte_di;
            exp_addr0++;
        end
        if (bus0.done) begin
            done0++;
            donecyc0 = cyc;
        end

        if (bus8.busy && !prev_busy8) exp_addr8 = 0;
        prev_busy8 = bus8.busy;
        if (bus8.byte_we) begin
            wr8++;
            if (!bus8.busy || int'(bus8.byte_addr) != exp_addr8 || exp_addr8 >= N8) bad8++;
            else cap8[bus8.byte_addr] = bus8.byte_di;
            exp_addr8++;
        end
        if (bus8.done) done8++;

        if (bus1.busy && !prev_busy1) exp_addr1 = 0;
        prev_busy1 = bus1.busy;
        if (bus1.byte_we) begin
            wr1++;
            if (!bus1.busy || int'(bus1.byte_addr) != exp_addr1 || exp_addr1 >= 1) bad1++;
            else cap1 = bus1.byte_di;
            exp_addr1++;
        end
        if (bus1.done) done1++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic setStart(input int which, input logic v);
        case (which)
            0:       bus0.start = v;
            1:       bus8.start = v;
            default: bus1.start = v;
        endcase
    endtask

    function automatic logic doneOf(input int which);
        case (which)
            0:       return bus0.done;
            1:       return bus8.done;
            default: return bus1.done;
        endcase
    endfunction

    // Pulse start for one cycle and wait (bounded) for the done pulse.
    task automatic applyStimulus(input int which, input string name);
        int n;
        @(negedge clk);
        setStart(which, 1'b1);
        @(negedge clk);
        setStart(which, 1'b0);
        n = 0;
        while (!doneOf(which) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " done seen"}, int'(n < BUDGET), 1);
        @(negedge clk);
    endtask

    function automatic int countBad0(input logic [23:0] pat);
        int bad;
        logic [7:0] want;
        bad = 0;
        for (int k = 0; k < NB0; k++) begin
            want = pat[8*(k%3) +: 8];
            if (cap0[k] !== want) bad++;
        end
        return bad;
    endfunction

    task automatic checkRun0(input string name, input int w, input int d, input int b,
                             input logic [23:0] pat, input logic err_exp);
        checkOutput({name, " writes"}, wr0 - w, NB0);
        checkOutput({name, " done pulses"}, done0 - d, 1);
        checkOutput({name, " addr/busy violations"}, bad0 - b, 0);
        checkOutput({name, " wrong bytes"}, countBad0(pat), 0);
        checkOutput({name, " err"}, int'(bus0.err), int'(err_exp));
        checkOutput({name, " done gap after last write"}, donecyc0 - lastwe0, 1);
        checkOutput({name, " last write within N+4"}, int'((lastwe0 - acc0) <= N0 + 4), 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [NV];
        logic [15:0] t2 [8];
        logic [23:0] pat;
        int          w, d, b, n, bad;

        vecs[0]  = '{16'd0,     3'd0, 1'b0};
        vecs[1]  = '{16'd768,   3'd0, 1'b0};
        vecs[2]  = '{16'd769,   3'd1, 1'b0};
        vecs[3]  = '{16'd2304,  3'd1, 1'b0};
        vecs[4]  = '{16'd2305,  3'd2, 1'b0};
        vecs[5]  = '{16'd3841,  3'd3, 1'b0};
        vecs[6]  = '{16'd6144,  3'd4, 1'b0};
        vecs[7]  = '{16'd9984,  3'd6, 1'b0};
        vecs[8]  = '{16'd9985,  3'd7, 1'b0};
        vecs[9]  = '{16'd11520, 3'd7, 1'b0};
        vecs[10] = '{16'd11521, 3'd0, 1'b0};
        vecs[11] = '{16'd12288, 3'd0, 1'b0};
        vecs[12] = '{16'd12289, 3'd0, 1'b1};
        vecs[13] = '{16'd65535, 3'd0, 1'b1};

        t2[0] = 16'd769;  t2[1] = 16'd2305; t2[2] = 16'd3841; t2[3] = 16'd5377;
        t2[4] = 16'd6913; t2[5] = 16'd8449; t2[6] = 16'd9985; t2[7] = 16'd11520;

        rst_n      = 1'b0;
        bus0.start = 1'b0;
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        for (int i = 0; i < N0; i++) mem0[i] = 16'd0;
        for (int i = 0; i < N8; i++) mem8[i] = 16'd6144;
        for (int i = 0; i < N1; i++) mem1[i] = (i % 2 == 1) ? 16'd6144 : 16'd0;

        #12;
        checkOutput("reset busy", int'(bus0.busy), 0);
        checkOutput("reset done", int'(bus0.done), 0);
        checkOutput("reset err", int'(bus0.err), 0);
        checkOutput("reset byte_we", int'(bus0.byte_we), 0);
        checkOutput("reset poly_addra", int'(bus0.poly_addra), 0);
        checkOutput("reset byte_addr", int'(bus0.byte_addr), 0);
        checkOutput("reset byte_di", int'(bus0.byte_di), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: every coefficient equal to x, so the stream repeats c eight
        // times per 3 bytes.
        for (int r = 0; r < NV; r++) begin
            for (int i = 0; i < N0; i++) mem0[i] = vecs[r].x;
            pat = '0;
            for (int i = 0; i < 8; i++) pat[3*i +: 3] = vecs[r].c;
            w = wr0; d = done0; b = bad0;
            applyStimulus(0, $sformatf("vec%0d x=%0d", r, vecs[r].x));
            checkRun0($sformatf("vec%0d x=%0d", r, vecs[r].x), w, d, b, pat, vecs[r].err);
        end

        // T2: mixed pattern right after an err run; err must be cleared.
        for (int i = 0; i < N0; i++) mem0[i] = t2[i % 8];
        w = wr0; d = done0; b = bad0;
        applyStimulus(0, "T2");
        checkRun0("T2", w, d, b, 24'hFF58D1, 1'b0);

        // T3: rounding boundaries and an out-of-range value at the start.
        for (int i = 0; i < N0; i++) mem0[i] = 16'd0;
        mem0[0] = 16'd768; mem0[1] = 16'd11521; mem0[2] = 16'd12288; mem0[3] = 16'd12289;
        w = wr0; d = done0; b = bad0;
        applyStimulus(0, "T3");
        checkRun0("T3", w, d, b, 24'h000000, 1'b1);
        checkOutput("T3 byte0", int'(cap0[0]), 0);
        for (int i = 0; i < 4; i++) mem0[i] = 16'd0;
        applyStimulus(0, "T3 rerun");
        checkOutput("T3 err cleared", int'(bus0.err), 0);

        // T4: D=8 and D=1 instances.
        w = wr8; d = done8; b = bad8;
        applyStimulus(1, "T4 D8");
        checkOutput("T4 D8 writes", wr8 - w, N8);
        checkOutput("T4 D8 done pulses", done8 - d, 1);
        checkOutput("T4 D8 addr/busy violations", bad8 - b, 0);
        bad = 0;
        for (int k = 0; k < N8; k++) if (cap8[k] !== 8'h80) bad++;
        checkOutput("T4 D8 wrong bytes", bad, 0);
        checkOutput("T4 D8 err", int'(bus8.err), 0);

        w = wr1; d = done1; b = bad1;
        applyStimulus(2, "T4 D1");
        checkOutput("T4 D1 writes", wr1 - w, 1);
        checkOutput("T4 D1 done pulses", done1 - d, 1);
        checkOutput("T4 D1 addr/busy violations", bad1 - b, 0);
        checkOutput("T4 D1 byte", int'(cap1), 8'hAA);

        // T5: asynchronous reset in the middle of a run.
        for (int i = 0; i < N0; i++) mem0[i] = t2[i % 8];
        w = wr0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (98) @(negedge clk);
        checkOutput("T5 writes before abort", int'(wr0 > w), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("T5 busy after reset", int'(bus0.busy), 0);
        checkOutput("T5 byte_we after reset", int'(bus0.byte_we), 0);
        checkOutput("T5 poly_addra after reset", int'(bus0.poly_addra), 0);
        checkOutput("T5 byte_addr after reset", int'(bus0.byte_addr), 0);
        checkOutput("T5 byte_di after reset", int'(bus0.byte_di), 0);
        w = wr0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("T5 writes after abort", wr0 - w, 0);
        checkOutput("T5 idle after abort", int'(bus0.busy), 0);
        for (int i = 0; i < N0; i++) mem0[i] = 16'd0;
        for (int i = 0; i < N0; i++) mem0[i] = t2[i % 8];
        w = wr0; d = done0; b = bad0;
        applyStimulus(0, "T5 restart");
        checkRun0("T5 restart", w, d, b, 24'hFF58D1, 1'b0);

        // T6a: start held high through the whole run, dropped on the done cycle.
        w = wr0; d = done0; b = bad0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        n = 0;
        while (bus0.busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        bus0.start = 1'b0;
        checkOutput("T6 held done on busy drop", int'(bus0.done), 1);
        repeat (3) @(negedge clk);
        checkOutput("T6 held writes", wr0 - w, NB0);
        checkOutput("T6 held done pulses", done0 - d, 1);
        checkOutput("T6 held no second run", int'(bus0.busy), 0);
        checkOutput("T6 held violations", bad0 - b, 0);

        // T6b: start raised on the done cycle begins a second run.
        w = wr0; d = done0; b = bad0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        n = 0;
        while (!bus0.done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("T6 first done seen", int'(bus0.done), 1);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        checkOutput("T6 second run busy", int'(bus0.busy), 1);
        checkOutput("T6 second run byte_addr", int'(bus0.byte_addr), 0);
        n = 0;
        while (!bus0.done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("T6 second done seen", int'(bus0.done), 1);
        @(negedge clk);
        checkOutput("T6 back-to-back writes", wr0 - w, 2 * NB0);
        checkOutput("T6 back-to-back done pulses", done0 - d, 2);
        checkOutput("T6 back-to-back violations", bad0 - b, 0);
        checkOutput("T6 back-to-back wrong bytes", countBad0(24'hFF58D1), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
